pc_stack: RTL and testbench
===========================

# pc_stack

Parametrised program counter for the CR16 core with a built-in return-address stack. It generalises the single-register PC with hold, absolute jump, signed displacement, call (push link and jump) and return (pop) modes. It sits between the control FSM and instruction memory: the FSM issues one mode per enabled cycle and O_ADDRESS drives the fetch address. Stack overflow, stack underflow and illegal-mode events raise sticky fault flags for the FSM.

## Interface
- P_ADDRESS_WIDTH, 16, width of the PC, jump target and stack entries
- P_DISP_WIDTH, 8, width of the signed displacement input
- P_STACK_DEPTH, 4, number of return-address entries (power of two, ≥2)
- P_RESET_ADDRESS, 0, value loaded into O_ADDRESS on reset
- I_CLK  input  1  system clock, rising edge
- I_NRESET  input  1  reset, asynchronous, active-low
- I_ENABLE  input  1  step enable; the PC and stack update only when high
- I_MODE  input  3  operation select, type pc_mode_e
- I_ADDRESS  input  P_ADDRESS_WIDTH  absolute target for JUMP/CALL
- I_DISP  input  P_DISP_WIDTH  two's-complement displacement for DISP
- I_FAULT_CLEAR  input  1  synchronous clear of all sticky fault flags
- O_ADDRESS  output  P_ADDRESS_WIDTH  current PC, registered
- O_STACK_EMPTY  output  1  stack count == 0
- O_STACK_FULL  output  1  stack count == P_STACK_DEPTH
- O_OVERFLOW  output  1  sticky: CALL issued while the stack was full
- O_UNDERFLOW  output  1  sticky: RET issued while the stack was empty
- O_ILLEGAL  output  1  sticky: reserved mode issued

## Operation
- Reset (asynchronous, I_NRESET low): O_ADDRESS=P_RESET_ADDRESS, count=0, pointer=0, all flags 0, O_STACK_EMPTY=1, O_STACK_FULL=0. Stack contents are don't-care.
- I_ENABLE low: no state changes, including when I_MODE is illegal. I_FAULT_CLEAR still acts.
- Modes (applied on the rising edge with I_ENABLE high):
  - INCR=0: O_ADDRESS ← O_ADDRESS+1.
  - HOLD=1: no change.
  - JUMP=2: O_ADDRESS ← I_ADDRESS.
  - DISP=3: O_ADDRESS ← O_ADDRESS + sign-extend(I_DISP).
  - CALL=4: push O_ADDRESS+1, then O_ADDRESS ← I_ADDRESS.
  - RET=5: O_ADDRESS ← top of stack, then pop.
  - 6 and 7: behave as HOLD and set O_ILLEGAL.
- Arithmetic: all sums are modulo 2^P_ADDRESS_WIDTH. 0xFFFF+1 wraps to 0x0000, and the pushed link wraps the same way.
- CALL when full: the jump is still taken. The push overwrites the oldest entry (circular buffer), count stays at P_STACK_DEPTH, and O_OVERFLOW is set.
- RET when empty: behaves as INCR, count stays 0, and O_UNDERFLOW is set.
- Fault flags: once set, a flag stays set until I_FAULT_CLEAR. If a clear and a new fault occur in the same cycle, the new fault wins and its flag ends set. Other flags are cleared.
- Reset mid-operation aborts any in-progress push or pop. No partial stack update is visible afterwards.

## Timing
- Single-cycle latency: a mode sampled at edge N is visible on O_ADDRESS and the flags after edge N.
- All outputs come from registers; there is no combinational path from inputs to outputs.
- A RET issued on the cycle immediately after a CALL returns that call's link, so back-to-back CALL→RET is legal every cycle.
- The FSM may issue any mode on every enabled cycle. There is no stall output.

## Structure
- cr16_pkg gains `pc_mode_e` (3-bit enum INCR, HOLD, JUMP, DISP, CALL, RET) and a `PC_MODE_WIDTH` constant.
- Sub-module `pc_ras` is a circular LIFO holding the entry array, the top pointer and a 0..P_STACK_DEPTH count. It has push/pop strobes, a top-of-stack output and full/empty outputs, and overwrites the oldest entry on push-when-full.
- The top level, pc_stack, holds the PC register, the mode decode, the displacement adder and the fault flags.

## Test plan
- Reset with P_RESET_ADDRESS=0x0100, then 3 INCR → O_ADDRESS 0x0101, 0x0102, 0x0103; every flag 0; O_STACK_EMPTY=1.
- PC=0x0010: DISP I_DISP=0xFE → 0x000E. DISP I_DISP=0x7F → 0x008D. PC=0xFFFF: INCR → 0x0000.
- PC=0x0020: CALL 0x0400, then CALL 0x0800, then RET, then RET → 0x0400, 0x0800, 0x0401, 0x0021; O_STACK_EMPTY=1 at the end.
- Depth 4: 5 CALLs, then 4 RETs → O_OVERFLOW=1 after the 5th CALL. The RETs return the last four links; the first link is lost. A 5th RET → INCR behaviour and O_UNDERFLOW=1.
- Mode 6 with I_ENABLE=1 → PC unchanged and O_ILLEGAL=1. Mode 6 with I_ENABLE=0 → no flag. I_FAULT_CLEAR in the same cycle as a RET-when-empty → O_UNDERFLOW=1 and O_ILLEGAL=0.
- Assert I_NRESET low mid-sequence with stack count=2 and asynchronous to I_CLK → O_ADDRESS=P_RESET_ADDRESS immediately, stack empty, flags 0. The first INCR after release → P_RESET_ADDRESS+1.

Source files
------------

// File: rtl/cr16_pkg.sv
// Shared CR16 definitions: program-counter operation modes.
package cr16_pkg;

   localparam int unsigned PC_MODE_WIDTH = 3;

   // Encodings 6 and 7 are reserved and decode as illegal.
   typedef enum logic [PC_MODE_WIDTH-1:0] {
      INCR = 3'd0,
      HOLD = 3'd1,
      JUMP = 3'd2,
      DISP = 3'd3,
      CALL = 3'd4,
      RET  = 3'd5
   } pc_mode_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address LIFO; a push when full overwrites the oldest entry.
module pc_ras #(
   parameter int unsigned P_WIDTH = 16,
   parameter int unsigned P_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic [P_WIDTH-1:0] push_data,
   output logic [P_WIDTH-1:0] top,
   output logic               full,
   output logic               empty
);

   localparam int unsigned PtrW = $clog2(P_DEPTH);
   localparam int unsigned CntW = $clog2(P_DEPTH + 1);

   logic [P_WIDTH-1:0] mem [P_DEPTH];
   logic [PtrW-1:0]    ptr_q, ptr_d;
   logic [CntW-1:0]    count_q, count_d;

   assign full  = (count_q == CntW'(P_DEPTH));
   assign empty = (count_q == '0);
   assign top   = mem[ptr_q];

   // The pointer always wraps, so a push when full lands on the oldest slot.
   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      if (push) begin
         ptr_d = ptr_q + PtrW'(1);
         if (!full) begin
            count_d = count_q + CntW'(1);
         end
      end else if (pop && !empty) begin
         ptr_d   = ptr_q - PtrW'(1);
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[ptr_d] <= push_data;
      end
   end

endmodule

// File: rtl/pc_stack.sv
// CR16 program counter with jump, displacement, call/return and sticky fault flags.
module pc_stack
   import cr16_pkg::*;
#(
   parameter int unsigned            P_ADDRESS_WIDTH = 16,
   parameter int unsigned            P_DISP_WIDTH    = 8,
   parameter int unsigned            P_STACK_DEPTH   = 4,
   parameter logic [P_ADDRESS_WIDTH-1:0] P_RESET_ADDRESS = '0
) (
   input  logic                       I_CLK,
   input  logic                       I_NRESET,
   input  logic                       I_ENABLE,
   input  logic [PC_MODE_WIDTH-1:0]   I_MODE,
   input  logic [P_ADDRESS_WIDTH-1:0] I_ADDRESS,
   input  logic [P_DISP_WIDTH-1:0]    I_DISP,
   input  logic                       I_FAULT_CLEAR,
   output logic [P_ADDRESS_WIDTH-1:0] O_ADDRESS,
   output logic                       O_STACK_EMPTY,
   output logic                       O_STACK_FULL,
   output logic                       O_OVERFLOW,
   output logic                       O_UNDERFLOW,
   output logic                       O_ILLEGAL
);

   logic [P_ADDRESS_WIDTH-1:0] pc_q, pc_d, pc_inc, disp_ext, ras_top;
   logic ovf_q, und_q, ilg_q;
   logic ovf_set, und_set, ilg_set;
   logic push, pop, ras_full, ras_empty;

   assign pc_inc   = pc_q + P_ADDRESS_WIDTH'(1);
   assign disp_ext = {{(P_ADDRESS_WIDTH - P_DISP_WIDTH){I_DISP[P_DISP_WIDTH-1]}}, I_DISP};

   always_comb begin
      pc_d    = pc_q;
      push    = 1'b0;
      pop     = 1'b0;
      ovf_set = 1'b0;
      und_set = 1'b0;
      ilg_set = 1'b0;
      if (I_ENABLE) begin
         case (I_MODE)
            INCR: pc_d = pc_inc;
            HOLD: pc_d = pc_q;
            JUMP: pc_d = I_ADDRESS;
            DISP: pc_d = pc_q + disp_ext;
            CALL: begin
               push    = 1'b1;
               ovf_set = ras_full;
               pc_d    = I_ADDRESS;
            end
            RET: begin
               // Return on an empty stack falls through as a plain increment.
               if (ras_empty) begin
                  und_set = 1'b1;
                  pc_d    = pc_inc;
               end else begin
                  pop  = 1'b1;
                  pc_d = ras_top;
               end
            end
            default: ilg_set = 1'b1;
         endcase
      end
   end

   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         pc_q  <= P_RESET_ADDRESS;
         ovf_q <= 1'b0;
         und_q <= 1'b0;
         ilg_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ovf_q <= (ovf_q & ~I_FAULT_CLEAR) | ovf_set;
         und_q <= (und_q & ~I_FAULT_CLEAR) | und_set;
         ilg_q <= (ilg_q & ~I_FAULT_CLEAR) | ilg_set;
      end
   end

   pc_ras #(
      .P_WIDTH (P_ADDRESS_WIDTH),
      .P_DEPTH (P_STACK_DEPTH)
   ) u_ras (
      .clk       (I_CLK),
      .rst_n     (I_NRESET),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .top       (ras_top),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   assign O_ADDRESS     = pc_q;
   assign O_STACK_EMPTY = ras_empty;
   assign O_STACK_FULL  = ras_full;
   assign O_OVERFLOW    = ovf_q;
   assign O_UNDERFLOW   = und_q;
   assign O_ILLEGAL     = ilg_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: modes, stack wrap/overflow/underflow, faults, async reset.
module tb_pc_stack;

   logic        clk = 1'b0;
   logic        nreset;
   logic        enable;
   logic [2:0]  mode;
   logic [15:0] address;
   logic [7:0]  disp;
   logic        fault_clear;
   logic [15:0] o_address;
   logic        o_empty, o_full, o_ovf, o_und, o_ilg;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   pc_stack #(
      .P_ADDRESS_WIDTH (16),
      .P_DISP_WIDTH    (8),
      .P_STACK_DEPTH   (4),
      .P_RESET_ADDRESS (16'h0100)
   ) dut (
      .I_CLK         (clk),
      .I_NRESET      (nreset),
      .I_ENABLE      (enable),
      .I_MODE        (mode),
      .I_ADDRESS     (address),
      .I_DISP        (disp),
      .I_FAULT_CLEAR (fault_clear),
      .O_ADDRESS     (o_address),
      .O_STACK_EMPTY (o_empty),
      .O_STACK_FULL  (o_full),
      .O_OVERFLOW    (o_ovf),
      .O_UNDERFLOW   (o_und),
      .O_ILLEGAL     (o_ilg)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Flags packed as {empty, full, ovf, und, ilg}.
   task automatic check_flags(input string tag, input logic [4:0] exp);
      check(tag, {11'd0, o_empty, o_full, o_ovf, o_und, o_ilg}, {11'd0, exp});
   endtask

   task automatic step(input logic [2:0] m, input logic [15:0] a, input logic [7:0] d,
                       input logic en, input logic clr);
      mode        = m;
      address     = a;
      disp        = d;
      enable      = en;
      fault_clear = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      nreset = 1'b0; enable = 1'b0; mode = 3'd1; address = '0; disp = '0; fault_clear = 1'b0;
      #12;
      check("reset_pc", o_address, 16'h0100);
      check_flags("reset_flags", 5'b10000);
      @(negedge clk);
      nreset = 1'b1;

      step(3'd0, 16'h0, 8'h0, 1'b1, 1'b0); check("incr1", o_address, 16'h0101);
      step(3'd0, 16'h0, 8'h0, 1'b1, 1'b0); check("incr2", o_address, 16'h0102);
      step(3'd0, 16'h0, 8'h0, 1'b1, 1'b0); check("incr3", o_address, 16'h0103);
      check_flags("incr_flags", 5'b10000);

      step(3'd2, 16'h0010, 8'h0, 1'b1, 1'b0); check("jump", o_address, 16'h0010);
      step(3'd3, 16'h0, 8'hFE, 1'b1, 1'b0);   check("disp_neg", o_address, 16'h000E);
      step(3'd3, 16'h0, 8'h7F, 1'b1, 1'b0);   check("disp_pos", o_address, 16'h008D);
      step(3'd1, 16'h0, 8'h0, 1'b1, 1'b0);    check("hold", o_address, 16'h008D);
      step(3'd2, 16'hFFFF, 8'h0, 1'b1, 1'b0);
      step(3'd0, 16'h0, 8'h0, 1'b1, 1'b0);    check("incr_wrap", o_address, 16'h0000);

      step(3'd2, 16'h0020, 8'h0, 1'b1, 1'b0);
      step(3'd4, 16'h0400, 8'h0, 1'b1, 1'b0); check("call1", o_address, 16'h0400);
      step(3'd4, 16'h0800, 8'h0, 1'b1, 1'b0); check("call2", o_address, 16'h0800);
      step(3'd5, 16'h0, 8'h0, 1'b1, 1'b0);    check("ret1", o_address, 16'h0401);
      step(3'd5, 16'h0, 8'h0, 1'b1, 1'b0);    check("ret2", o_address, 16'h0021);
      check_flags("nest_flags", 5'b10000);

      // Five calls into a depth-4 stack: the first link (0x1001) is lost.
      step(3'd2, 16'h1000, 8'h0, 1'b1, 1'b0);
      step(3'd4, 16'h2000, 8'h0, 1'b1, 1'b0);
      step(3'd4, 16'h3000, 8'h0, 1'b1, 1'b0);
      step(3'd4, 16'h4000, 8'h0, 1'b1, 1'b0);
      step(3'd4, 16'h5000, 8'h0, 1'b1, 1'b0);
      check_flags("full_no_ovf", 5'b01000);
      step(3'd4, 16'h6000, 8'h0, 1'b1, 1'b0);
      check("call5", o_address, 16'h6000);
      check_flags("ovf_set", 5'b01100);
      step(3'd5, 16'h0, 8'h0, 1'b1, 1'b0); check("oret1", o_address, 16'h5001);
      step(3'd5, 16'h0, 8'h0, 1'b1, 1'b0); check("oret2", o_address, 16'h4001);
      step(3'd5, 16'h0, 8'h0, 1'b1, 1'b0); check("oret3", o_address, 16'h3001);
      step(3'd5, 16'h0, 8'h0, 1'b1, 1'b0); check("oret4", o_address, 16'h2001);
      check_flags("drained", 5'b10100);
      step(3'd5, 16'h0, 8'h0, 1'b1, 1'b0); check("ret_empty", o_address, 16'h2002);
      check_flags("und_set", 5'b10110);

      step(3'd2, 16'hFFFF, 8'h0, 1'b1, 1'b0);
      step(3'd4, 16'h0300, 8'h0, 1'b1, 1'b0);
      step(3'd5, 16'h0, 8'h0, 1'b1, 1'b0);    check("link_wrap", o_address, 16'h0000);

      step(3'd0, 16'h0, 8'h0, 1'b0, 1'b1);    check("disabled_incr", o_address, 16'h0000);
      check_flags("cleared", 5'b10000);
      step(3'd6, 16'h0, 8'h0, 1'b0, 1'b0);    check_flags("ilg_disabled", 5'b10000);
      step(3'd6, 16'h0, 8'h0, 1'b1, 1'b0);    check("ilg_pc", o_address, 16'h0000);
      check_flags("ilg_set", 5'b10001);
      step(3'd7, 16'h0, 8'h0, 1'b1, 1'b0);    check("ilg7_pc", o_address, 16'h0000);
      step(3'd5, 16'h0, 8'h0, 1'b1, 1'b1);    check("clr_ret_pc", o_address, 16'h0001);
      check_flags("clr_vs_und", 5'b10010);

      step(3'd4, 16'h0A00, 8'h0, 1'b1, 1'b0);
      step(3'd4, 16'h0B00, 8'h0, 1'b1, 1'b0);
      check_flags("two_deep", 5'b00010);
      #3 nreset = 1'b0;
      #1;
      check("async_rst_pc", o_address, 16'h0100);
      check_flags("async_rst_flags", 5'b10000);
      @(negedge clk);
      nreset = 1'b1;
      step(3'd0, 16'h0, 8'h0, 1'b1, 1'b0);    check("post_rst_incr", o_address, 16'h0101);
      step(3'd5, 16'h0, 8'h0, 1'b1, 1'b0);    check("post_rst_ret", o_address, 16'h0102);
      check_flags("post_rst_und", 5'b10010);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
